// File: rtl/dpram_dma_if.sv
// Control and RAM-port bundle for the dpram_dma copy/fill engine.
// master: control block plus RAM side; slave: the DMA engine.
interface dpram_dma_if #(
  parameter int unsigned RAM_DEPTH = 2048
);
  localparam int unsigned AW = $clog2(RAM_DEPTH);

  logic          start;
  logic          mode;
  logic          dir;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW:0]   len;
  logic [31:0]   fill_data;
  logic          abort;
  logic          busy;
  logic          done;
  logic          err;
  logic          ram_ena;
  logic [AW-1:0] ram_addra;
  logic [31:0]   ram_douta;
  logic          ram_enb;
  logic          ram_web;
  logic [3:0]    ram_wemb;
  logic [AW-1:0] ram_addrb;
  logic [31:0]   ram_dinb;

  modport master (
    output start, mode, dir, src_addr, dst_addr, len, fill_data, abort, ram_douta,
    input  busy, done, err, ram_ena, ram_addra, ram_enb, ram_web, ram_wemb, ram_addrb, ram_dinb
  );

  modport slave (
    input  start, mode, dir, src_addr, dst_addr, len, fill_data, abort, ram_douta,
    output busy, done, err, ram_ena, ram_addra, ram_enb, ram_web, ram_wemb, ram_addrb, ram_dinb
  );
endinterface

// File: rtl/dpram_dma.sv
// Word copy/fill DMA over a dual-port RAM: reads on port A, writes on port B,
// one word per clock, ascending or descending to handle overlapping regions.
module dpram_dma #(
  parameter int unsigned RAM_DEPTH = 2048
) (
  input logic        clk,
  input logic        rst,
  dpram_dma_if.slave bus
);
  localparam int unsigned AW = $clog2(RAM_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(RAM_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_nxt;

  logic          mode_q, dir_q;
  logic [AW-1:0] src_q, dst_q, rd_idx_q;
  logic [LW-1:0] len_q, cnt_q;
  logic [31:0]   fill_q;

  logic          ena_q, enb_q, busy_q, done_q, err_q;
  logic [AW-1:0] addra_q, addrb_q;
  logic [3:0]    wemb_q;

  logic          ena_d, enb_d, busy_d, done_d, err_d;
  logic [AW-1:0] addra_d, addrb_d;
  logic [3:0]    wemb_d;

  logic          sel_mode, sel_dir;
  logic [AW-1:0] sel_src, sel_dst, beat_idx;
  logic [LW-1:0] sel_len;
  logic          len_ok, accept, more, issue;

  // In IDLE the first beat is issued straight from the request inputs.
  always_comb begin
    sel_mode = mode_q;
    sel_dir  = dir_q;
    sel_src  = src_q;
    sel_dst  = dst_q;
    sel_len  = len_q;
    if (state == IDLE) begin
      sel_mode = bus.mode;
      sel_dir  = bus.dir;
      sel_src  = bus.src_addr;
      sel_dst  = bus.dst_addr;
      sel_len  = bus.len;
    end
  end

  assign len_ok   = (bus.len != '0) && (bus.len <= DEPTH_L);
  assign accept   = (state == IDLE) && bus.start && len_ok;
  assign more     = cnt_q < sel_len;
  assign beat_idx = sel_dir ? AW'(sel_len - cnt_q - LW'(1)) : AW'(cnt_q);
  assign issue    = accept || ((state == RUN) && more && !bus.abort);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (bus.start) state_nxt = len_ok ? RUN : DONE;
      RUN:   if (bus.abort || !more) state_nxt = mode_q ? DONE : FLUSH;
      FLUSH: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; a read in flight is always written next cycle.
  always_comb begin
    ena_d   = 1'b0;
    addra_d = '0;
    enb_d   = 1'b0;
    addrb_d = '0;
    wemb_d  = 4'h0;
    busy_d  = (state_nxt == RUN) || (state_nxt == FLUSH);
    done_d  = (state_nxt == DONE);
    err_d   = err_q;
    if ((state == IDLE) && bus.start) err_d = (bus.len > DEPTH_L);
    if (issue && !sel_mode) begin
      ena_d   = 1'b1;
      addra_d = sel_src + beat_idx;
    end
    if (issue && sel_mode) begin
      enb_d   = 1'b1;
      addrb_d = sel_dst + beat_idx;
    end else if (ena_q) begin
      enb_d   = 1'b1;
      addrb_d = dst_q + rd_idx_q;
    end
    if (enb_d) wemb_d = 4'hF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ena_q    <= 1'b0;
      addra_q  <= '0;
      enb_q    <= 1'b0;
      addrb_q  <= '0;
      wemb_q   <= 4'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mode_q   <= 1'b0;
      dir_q    <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
      rd_idx_q <= '0;
    end else begin
      ena_q   <= ena_d;
      addra_q <= addra_d;
      enb_q   <= enb_d;
      addrb_q <= addrb_d;
      wemb_q  <= wemb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (accept) begin
        mode_q <= bus.mode;
        dir_q  <= bus.dir;
        src_q  <= bus.src_addr;
        dst_q  <= bus.dst_addr;
        len_q  <= bus.len;
        fill_q <= bus.fill_data;
      end
      if (ena_d) rd_idx_q <= beat_idx;
      if (issue)                    cnt_q <= cnt_q + LW'(1);
      else if (state_nxt == IDLE)   cnt_q <= '0;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.ram_ena   = ena_q;
  assign bus.ram_addra = addra_q;
  assign bus.ram_enb   = enb_q;
  assign bus.ram_web   = enb_q;
  assign bus.ram_wemb  = wemb_q;
  assign bus.ram_addrb = addrb_q;
  // Copy data passes straight from port A to port B; forced to 0 when not writing.
  assign bus.ram_dinb  = enb_q ? (mode_q ? fill_q : bus.ram_douta) : '0;
endmodule

// File: tb/tb_dpram_dma.sv
// Directed bench for dpram_dma with a behavioural dual-port RAM.
module tb_dpram_dma;
  localparam int unsigned D  = 2048;
  localparam int unsigned AW = $clog2(D);
  localparam int unsigned LW = AW + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dpram_dma_if #(.RAM_DEPTH(D)) bus ();
  dpram_dma #(.RAM_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vecs = 0;
  int errs = 0;

  // RAM model with a backdoor preload port
  logic [31:0]   mem [0:D-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [31:0]   pl_data = '0;
  always @(posedge clk) begin
    if (bus.ram_ena) bus.ram_douta <= mem[bus.ram_addra];
    if (bus.ram_enb && bus.ram_web)
      for (int b = 0; b < 4; b++)
        if (bus.ram_wemb[b]) mem[bus.ram_addrb][8*b +: 8] <= bus.ram_dinb[8*b +: 8];
    if (pl_en) mem[pl_addr] <= pl_data;
  end

  int busy_cnt = 0, done_cnt = 0, ena_cnt = 0, enb_cnt = 0, stray_cnt = 0, wemb_bad = 0;
  always @(negedge clk) begin
    if (bus.busy) busy_cnt <= busy_cnt + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
    if (bus.ram_ena) ena_cnt <= ena_cnt + 1;
    if (bus.ram_enb && bus.ram_web) enb_cnt <= enb_cnt + 1;
    if ((bus.ram_ena || bus.ram_enb) && !bus.busy) stray_cnt <= stray_cnt + 1;
    if (bus.ram_enb && bus.ram_wemb != 4'hF) wemb_bad <= wemb_bad + 1;
  end

  task automatic pl_word(input int a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = AW'(a); pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic run_xfer(input logic m, input logic d, input int s, input int t, input int n,
                          input logic [31:0] f, input logic ab,
                          output int busy_c, output int done_c, output int ena_c,
                          output int enb_c, output int lat, output bit to);
    int b0, d0, a0, e0;
    @(negedge clk);
    bus.mode = m; bus.dir = d; bus.src_addr = AW'(s); bus.dst_addr = AW'(t);
    bus.len = LW'(n); bus.fill_data = f; bus.abort = ab; bus.start = 1'b1;
    #1;
    b0 = busy_cnt; d0 = done_cnt; a0 = ena_cnt; e0 = enb_cnt;
    lat = 0; to = 1'b1;
    for (int k = 1; k <= 3 * D; k++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      #1;
      if (done_cnt != d0) begin lat = k; to = 1'b0; break; end
    end
    repeat (3) @(negedge clk);
    #1;
    busy_c = busy_cnt - b0; done_c = done_cnt - d0; ena_c = ena_cnt - a0; enb_c = enb_cnt - e0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vecs++; if ({bus.busy, bus.done, bus.err, bus.ram_ena, bus.ram_enb, bus.ram_web} !== 6'b0) begin
      errs++; $display("FAIL reset_ctl: got %b want 000000", {bus.busy, bus.done, bus.err, bus.ram_ena, bus.ram_enb, bus.ram_web}); end
    vecs++; if ({bus.ram_wemb, bus.ram_addra, bus.ram_addrb, bus.ram_dinb} !== '0) begin
      errs++; $display("FAIL reset_bus: got %h want 0", {bus.ram_wemb, bus.ram_addra, bus.ram_addrb, bus.ram_dinb}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vecs++; if ({bus.busy, bus.done, bus.ram_ena, bus.ram_enb} !== 4'b0) begin
      errs++; $display("FAIL idle_after_reset: got %b want 0000", {bus.busy, bus.done, bus.ram_ena, bus.ram_enb}); end
  endtask

  task automatic test_copy_up();
    int bc, dc, ac, ec, lat; bit to;
    for (int k = 0; k < 8; k++) begin pl_word(k, 32'h100 + k); pl_word(16 + k, 32'h0); end
    run_xfer(1'b0, 1'b0, 0, 16, 8, 32'h0, 1'b0, bc, dc, ac, ec, lat, to);
    vecs++; if (to !== 1'b0) begin errs++; $display("FAIL copy_up_timeout: got %0d want 0", to); end
    for (int k = 0; k < 8; k++) begin
      vecs++; if (mem[16 + k] !== 32'h100 + k) begin
        errs++; $display("FAIL copy_up_data[%0d]: got %h want %h", 16 + k, mem[16 + k], 32'h100 + k); end
    end
    vecs++; if (bc !== 9)   begin errs++; $display("FAIL copy_up_busy: got %0d want 9", bc); end
    vecs++; if (dc !== 1)   begin errs++; $display("FAIL copy_up_done: got %0d want 1", dc); end
    vecs++; if (lat !== 10) begin errs++; $display("FAIL copy_up_latency: got %0d want 10", lat); end
    vecs++; if (ac !== 8 || ec !== 8) begin errs++; $display("FAIL copy_up_beats: got rd %0d wr %0d want 8 8", ac, ec); end
    vecs++; if (bus.err !== 1'b0) begin errs++; $display("FAIL copy_up_err: got %b want 0", bus.err); end
  endtask

  task automatic test_overlap_down();
    int bc, dc, ac, ec, lat; bit to;
    logic [31:0] exp_w [10] = '{32'd0, 32'd1, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
    for (int k = 0; k < 10; k++) pl_word(k, 32'(k));
    run_xfer(1'b0, 1'b1, 0, 2, 8, 32'h0, 1'b0, bc, dc, ac, ec, lat, to);
    vecs++; if (to !== 1'b0) begin errs++; $display("FAIL overlap_timeout: got %0d want 0", to); end
    for (int k = 0; k < 10; k++) begin
      vecs++; if (mem[k] !== exp_w[k]) begin
        errs++; $display("FAIL overlap_data[%0d]: got %h want %h", k, mem[k], exp_w[k]); end
    end
    vecs++; if (bc !== 9) begin errs++; $display("FAIL overlap_busy: got %0d want 9", bc); end
  endtask

  task automatic test_fill_wrap();
    int bc, dc, ac, ec, lat; bit to;
    pl_word(D - 3, 32'h0BAD0001); pl_word(D - 2, 32'h0); pl_word(D - 1, 32'h0);
    pl_word(0, 32'h0); pl_word(1, 32'h0); pl_word(2, 32'h0BAD0002);
    run_xfer(1'b1, 1'b0, 0, D - 2, 4, 32'hDEADBEEF, 1'b0, bc, dc, ac, ec, lat, to);
    vecs++; if (to !== 1'b0) begin errs++; $display("FAIL fill_timeout: got %0d want 0", to); end
    vecs++; if (mem[D-2] !== 32'hDEADBEEF || mem[D-1] !== 32'hDEADBEEF) begin
      errs++; $display("FAIL fill_top: got %h %h want deadbeef deadbeef", mem[D-2], mem[D-1]); end
    vecs++; if (mem[0] !== 32'hDEADBEEF || mem[1] !== 32'hDEADBEEF) begin
      errs++; $display("FAIL fill_wrap: got %h %h want deadbeef deadbeef", mem[0], mem[1]); end
    vecs++; if (mem[D-3] !== 32'h0BAD0001 || mem[2] !== 32'h0BAD0002) begin
      errs++; $display("FAIL fill_bounds: got %h %h want 0bad0001 0bad0002", mem[D-3], mem[2]); end
    vecs++; if (bc !== 4)  begin errs++; $display("FAIL fill_busy: got %0d want 4", bc); end
    vecs++; if (lat !== 5) begin errs++; $display("FAIL fill_latency: got %0d want 5", lat); end
    vecs++; if (ac !== 0 || ec !== 4) begin errs++; $display("FAIL fill_beats: got rd %0d wr %0d want 0 4", ac, ec); end
  endtask

  task automatic test_len_edges();
    int bc, dc, ac, ec, lat; bit to;
    run_xfer(1'b0, 1'b0, 0, 16, 0, 32'h0, 1'b0, bc, dc, ac, ec, lat, to);
    vecs++; if (lat !== 1 || dc !== 1) begin errs++; $display("FAIL len0_done: got lat %0d pulses %0d want 1 1", lat, dc); end
    vecs++; if (bc !== 0 || ac !== 0 || ec !== 0) begin
      errs++; $display("FAIL len0_access: got busy %0d rd %0d wr %0d want 0 0 0", bc, ac, ec); end
    vecs++; if (bus.err !== 1'b0) begin errs++; $display("FAIL len0_err: got %b want 0", bus.err); end
    run_xfer(1'b0, 1'b0, 0, 16, D + 1, 32'h0, 1'b0, bc, dc, ac, ec, lat, to);
    vecs++; if (lat !== 1 || dc !== 1) begin errs++; $display("FAIL lenbig_done: got lat %0d pulses %0d want 1 1", lat, dc); end
    vecs++; if (bc !== 0 || ac !== 0 || ec !== 0) begin
      errs++; $display("FAIL lenbig_access: got busy %0d rd %0d wr %0d want 0 0 0", bc, ac, ec); end
    vecs++; if (bus.err !== 1'b1) begin errs++; $display("FAIL lenbig_err: got %b want 1", bus.err); end
  endtask

  task automatic test_abort();
    int b0, d0, e0;
    bit to;
    for (int k = 0; k < 16; k++) pl_word(32 + k, 32'h200 + k);
    for (int k = 0; k < 4; k++) pl_word(64 + k, 32'h0);
    @(negedge clk);
    bus.mode = 1'b0; bus.dir = 1'b0; bus.src_addr = AW'(32); bus.dst_addr = AW'(64);
    bus.len = LW'(16); bus.abort = 1'b0; bus.start = 1'b1;
    #1; b0 = busy_cnt; d0 = done_cnt; e0 = enb_cnt;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk); bus.abort = 1'b1;
    @(negedge clk); bus.abort = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) begin to = 1'b0; break; end
    end
    repeat (3) @(negedge clk); #1;
    vecs++; if (to !== 1'b0) begin errs++; $display("FAIL abort_timeout: got %0d want 0", to); end
    vecs++; if (enb_cnt - e0 !== 3) begin errs++; $display("FAIL abort_writes: got %0d want 3", enb_cnt - e0); end
    for (int k = 0; k < 3; k++) begin
      vecs++; if (mem[64 + k] !== 32'h200 + k) begin
        errs++; $display("FAIL abort_data[%0d]: got %h want %h", 64 + k, mem[64 + k], 32'h200 + k); end
    end
    vecs++; if (mem[67] !== 32'h0) begin errs++; $display("FAIL abort_extra: got %h want 0", mem[67]); end
    vecs++; if (busy_cnt - b0 !== 4) begin errs++; $display("FAIL abort_busy: got %0d want 4", busy_cnt - b0); end
    vecs++; if (done_cnt - d0 !== 1) begin errs++; $display("FAIL abort_done: got %0d want 1", done_cnt - d0); end
    vecs++; if (bus.err !== 1'b0) begin errs++; $display("FAIL abort_err: got %b want 0", bus.err); end
  endtask

  task automatic test_rst_mid();
    int bc, dc, ac, ec, lat; bit to;
    for (int k = 0; k < 4; k++) pl_word(128 + k, 32'h0);
    @(negedge clk);
    bus.mode = 1'b0; bus.dir = 1'b0; bus.src_addr = AW'(32); bus.dst_addr = AW'(96);
    bus.len = LW'(16); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vecs++; if ({bus.busy, bus.done, bus.ram_ena, bus.ram_enb, bus.ram_web} !== 5'b0) begin
      errs++; $display("FAIL rst_mid_ctl: got %b want 00000", {bus.busy, bus.done, bus.ram_ena, bus.ram_enb, bus.ram_web}); end
    vecs++; if ({bus.ram_wemb, bus.ram_addra, bus.ram_addrb, bus.ram_dinb} !== '0) begin
      errs++; $display("FAIL rst_mid_bus: got %h want 0", {bus.ram_wemb, bus.ram_addra, bus.ram_addrb, bus.ram_dinb}); end
    @(negedge clk); rst = 1'b0;
    // abort raised together with start must be ignored
    run_xfer(1'b0, 1'b0, 32, 128, 4, 32'h0, 1'b1, bc, dc, ac, ec, lat, to);
    vecs++; if (to !== 1'b0) begin errs++; $display("FAIL post_rst_timeout: got %0d want 0", to); end
    for (int k = 0; k < 4; k++) begin
      vecs++; if (mem[128 + k] !== 32'h200 + k) begin
        errs++; $display("FAIL post_rst_data[%0d]: got %h want %h", 128 + k, mem[128 + k], 32'h200 + k); end
    end
    vecs++; if (bc !== 5 || dc !== 1 || ec !== 4) begin
      errs++; $display("FAIL post_rst_beats: got busy %0d done %0d wr %0d want 5 1 4", bc, dc, ec); end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.mode = 1'b0; bus.dir = 1'b0; bus.abort = 1'b0;
    bus.src_addr = '0; bus.dst_addr = '0; bus.len = '0; bus.fill_data = '0;
    test_reset();
    test_copy_up();
    test_overlap_down();
    test_fill_wrap();
    test_len_edges();
    test_abort();
    test_rst_mid();
    vecs++; if (stray_cnt !== 0) begin errs++; $display("FAIL stray_enable: got %0d want 0", stray_cnt); end
    vecs++; if (wemb_bad !== 0) begin errs++; $display("FAIL byte_enables: got %0d want 0", wemb_bad); end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
